apb_initiator: RTL and testbench
================================

APB_INITIATOR -- requirements
Module: apb_initiator

Interface
REQ-001 Parameters SHALL be (name, default, meaning): ADDR_W, 8, PADDR width.
REQ-002 DATA_W, 32, PWDATA/PRDATA width.
REQ-003 TIMEOUT, 255, maximum ACCESS cycles before abort; legal range 1..65535.
REQ-004 Ports SHALL be (name, direction, width, meaning):
PCLK  in  1  sole clock, rising-edge.
PRESET  in  1  reset, synchronous, active-high.
req_valid  in  1  command offered.
req_ready  out  1  command accepted when req_valid&req_ready.
req_addr  in  ADDR_W  target address.
req_write  in  1  1=write, 0=read.
req_wdata  in  DATA_W  write data.
rsp_valid  out  1  response held.
rsp_ready  in  1  response consumed when rsp_valid&rsp_ready.
rsp_rdata  out  DATA_W  captured PRDATA; 0 on writes and timeouts.
rsp_err  out  1  PSLVERR captured, or timeout.
rsp_timeout  out  1  transfer aborted by timeout.
PADDR  out  ADDR_W  APB address.
PSEL  out  1  APB select.
PENABLE  out  1  APB enable.
PWRITE  out  1  APB direction.
PWDATA  out  DATA_W  APB write data.
PRDATA  in  DATA_W  APB read data.
PREADY  in  1  APB ready.
PSLVERR  in  1  APB slave error.

Function
REQ-005 FSM SHALL have states IDLE, SETUP, ACCESS, RESP.
REQ-006 req_ready SHALL be 1 only in IDLE; acceptance registers addr/write/wdata and moves to SETUP next cycle.
REQ-007 SETUP SHALL drive PSEL=1, PENABLE=0 for exactly one cycle, then enter ACCESS.
REQ-008 ACCESS SHALL drive PSEL=1, PENABLE=1; PADDR/PWRITE/PWDATA SHALL be stable from SETUP through ACCESS completion.
REQ-009 In ACCESS with PREADY=1: capture PRDATA (reads only, else 0) and PSLVERR into rsp_rdata/rsp_err, clear rsp_timeout, enter RESP; PSEL/PENABLE drop next cycle.
REQ-010 ACCESS cycle counter SHALL start at 1 on the first ACCESS cycle; if PREADY=0 on the cycle count equals TIMEOUT, transfer SHALL abort: rsp_err=1, rsp_timeout=1, rsp_rdata=0, enter RESP.
REQ-011 PREADY=1 on the TIMEOUT cycle SHALL count as normal completion, not timeout.
REQ-012 RESP SHALL assert rsp_valid with stable fields until rsp_ready; on handshake return to IDLE; rsp_ready=0 holds RESP indefinitely.
REQ-013 Minimum latency: accept at cycle N, SETUP N+1, ACCESS N+2, rsp_valid N+3 with zero wait states; next accept no earlier than the cycle after response handshake.
REQ-014 PSEL and PENABLE SHALL be 0 in IDLE and RESP; no back-to-back transfers without an IDLE cycle.
REQ-015 PADDR/PWRITE/PWDATA outside transfers SHALL hold last values (no spec on content).

Reset
REQ-016 PRESET=1 at a rising PCLK edge SHALL force IDLE, clear counter, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0; req_ready=0 while PRESET is high.
REQ-017 Reset mid-transfer (SETUP/ACCESS/RESP) SHALL abandon the transfer with no response; PSEL drops the cycle after reset is sampled.

Structure
REQ-018 State enum and default ADDR_W/DATA_W/TIMEOUT constants SHALL live in shared package apb_pkg.
REQ-019 Single module; timeout counter width SHALL be $clog2(TIMEOUT+1); no sub-modules.

Verification
REQ-020 Write 0x0C←0xDEADBEEF, PREADY tied 1 -> PSEL rises N+1, PENABLE N+2, rsp_valid N+3, rsp_err=0, rsp_rdata=0.
REQ-021 Read 0x04, PREADY low 3 ACCESS cycles then high with PRDATA=0x00000055 -> rsp_rdata=0x55, PSEL high 5 cycles, PADDR stable.
REQ-022 Read with PSLVERR=1 on completion -> rsp_err=1, rsp_timeout=0.
REQ-023 TIMEOUT=4, PREADY held 0 -> abort after 4th ACCESS cycle, rsp_err=1, rsp_timeout=1, rsp_rdata=0; PREADY=1 on 4th cycle -> normal completion.
REQ-024 rsp_ready held 0 for 10 cycles with req_valid=1 -> rsp fields stable, req_ready=0, no new PSEL.
REQ-025 PRESET pulsed during ACCESS -> next cycle PSEL=0, rsp_valid=0, FSM IDLE, next request completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// -----------------------------------------------------------------------------
// apb_pkg
// Shared definitions for the APB initiator: default parameter values and the
// transfer FSM state type.
// -----------------------------------------------------------------------------
package apb_pkg;

  localparam int unsigned APB_ADDR_W_DEF  = 8;
  localparam int unsigned APB_DATA_W_DEF  = 32;
  localparam int unsigned APB_TIMEOUT_DEF = 255;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

endpackage

// File: rtl/apb_initiator.sv
// -----------------------------------------------------------------------------
// apb_initiator
// Converts one request/response handshake into a single APB transfer
// (SETUP then ACCESS), with an ACCESS-phase wait-state timeout.
//
// Ports
//   PCLK, PRESET              clock (rising edge), synchronous active-high reset
//   req_valid/req_ready       command handshake; addr/write/wdata captured on accept
//   req_addr/write/wdata      command fields
//   rsp_valid/rsp_ready       response handshake; fields held until consumed
//   rsp_rdata                 captured PRDATA (0 for writes and timeouts)
//   rsp_err                   PSLVERR captured, or timeout
//   rsp_timeout               transfer aborted after TIMEOUT ACCESS cycles
//   PADDR..PSLVERR            APB initiator-side signals
// -----------------------------------------------------------------------------
module apb_initiator
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = APB_ADDR_W_DEF,
  parameter int unsigned DATA_W  = APB_DATA_W_DEF,
  parameter int unsigned TIMEOUT = APB_TIMEOUT_DEF
) (
  input  logic              PCLK,
  input  logic              PRESET,

  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_write,
  input  logic [DATA_W-1:0] req_wdata,

  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,

  output logic [ADDR_W-1:0] PADDR,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  localparam int unsigned     CNT_W     = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  apb_state_e       state_q;
  apb_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;
  logic             access_done;
  logic             access_timeout;

  // State register
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_d        = state_q;
    req_ready      = 1'b0;
    rsp_valid      = 1'b0;
    PSEL           = 1'b0;
    PENABLE        = 1'b0;
    accept         = 1'b0;
    access_done    = 1'b0;
    access_timeout = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Held off while reset is asserted so no command is consumed then.
        req_ready = ~PRESET;
        if (req_valid && !PRESET) begin
          accept  = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        PSEL    = 1'b1;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        // PREADY on the final counted cycle still wins over the timeout.
        if (PREADY) begin
          access_done = 1'b1;
          state_d     = ST_RESP;
        end else if (cnt_q == CNT_LIMIT) begin
          access_timeout = 1'b1;
          state_d        = ST_RESP;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Transfer fields, ACCESS cycle counter and response capture
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      PADDR       <= '0;
      PWRITE      <= 1'b0;
      PWDATA      <= '0;
      cnt_q       <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      if (accept) begin
        PADDR  <= req_addr;
        PWRITE <= req_write;
        PWDATA <= req_wdata;
      end

      // Counter reads 1 on the first ACCESS cycle; it never passes CNT_LIMIT
      // because ACCESS is left on the cycle it reaches it.
      if (state_q == ST_SETUP) begin
        cnt_q <= CNT_ONE;
      end else if (state_q == ST_ACCESS && !access_done && !access_timeout) begin
        cnt_q <= cnt_q + CNT_ONE;
      end

      if (access_done) begin
        rsp_rdata   <= PWRITE ? '0 : PRDATA;
        rsp_err     <= PSLVERR;
        rsp_timeout <= 1'b0;
      end else if (access_timeout) begin
        rsp_rdata   <= '0;
        rsp_err     <= 1'b1;
        rsp_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_initiator.sv
// -----------------------------------------------------------------------------
// tb_apb_initiator
// Directed and randomized transfers against apb_initiator (TIMEOUT=4). The
// bench acts as the APB completer and predicts each response from the wait
// state count, direction and completer data alone.
// -----------------------------------------------------------------------------
module tb_apb_initiator;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          req_write;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic [AW-1:0] PADDR;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  int n_checks = 0;
  int n_pass   = 0;

  apb_initiator #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .TIMEOUT(TO)
  ) dut (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_write  (req_write),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .PADDR      (PADDR),
    .PSEL       (PSEL),
    .PENABLE    (PENABLE),
    .PWRITE     (PWRITE),
    .PWDATA     (PWDATA),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY),
    .PSLVERR    (PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  function automatic logic rbit();
    return 1'($urandom);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  // One complete transfer. The completer holds PREADY low for 'waits' ACCESS
  // cycles and then raises it with prd/serr. The response is left pending for
  // 'hold' cycles before rsp_ready is given.
  task automatic xfer(input string tag, input logic [AW-1:0] addr, input logic wr,
                      input logic [DW-1:0] wd, input int waits, input logic [DW-1:0] prd,
                      input logic serr, input int hold, input logic keep_valid);
    int            n_acc;
    logic [DW-1:0] e_rd;
    logic          e_err;
    logic          e_to;
    int            rsp_cyc  = 0;
    int            psel_cnt = 0;
    int            acc      = 0;
    logic          proto_ok = 1'b1;
    logic          hold_ok  = 1'b1;
    logic          rdy;

    // Expected outcome: a transfer either completes after waits+1 ACCESS
    // cycles or is cut off after TO of them.
    if (waits < int'(TO)) begin
      n_acc = waits + 1;
      e_rd  = wr ? '0 : prd;
      e_err = serr;
      e_to  = 1'b0;
    end else begin
      n_acc = int'(TO);
      e_rd  = '0;
      e_err = 1'b1;
      e_to  = 1'b1;
    end

    req_addr  = addr;
    req_write = wr;
    req_wdata = wd;
    req_valid = 1'b1;
    check($sformatf("%s.accept_ready", tag), 64'(req_ready), 64'(1));

    for (int c = 1; c <= 60; c++) begin
      @(posedge PCLK); #1;
      if (!keep_valid) req_valid = 1'b0;
      if (rsp_valid === 1'b1) begin
        rsp_cyc = c;
        break;
      end
      // Until the response appears the bus must be in SETUP (c==1) or ACCESS.
      if (PSEL === 1'b1) psel_cnt++;
      if (PSEL !== 1'b1) proto_ok = 1'b0;
      if (PENABLE !== (c >= 2)) proto_ok = 1'b0;
      if (PADDR !== addr || PWRITE !== wr || PWDATA !== wd) proto_ok = 1'b0;

      if (PSEL === 1'b1 && PENABLE === 1'b1) begin
        acc++;
        rdy     = (acc > waits);
        PREADY  = rdy;
        PRDATA  = rdy ? prd : $urandom;
        PSLVERR = rdy ? serr : rbit();
      end else begin
        PREADY  = rbit();
        PRDATA  = $urandom;
        PSLVERR = rbit();
      end
    end
    PREADY = 1'b0;

    check($sformatf("%s.rsp_latency", tag), 64'(rsp_cyc), 64'(n_acc + 2));
    check($sformatf("%s.psel_cycles", tag), 64'(psel_cnt), 64'(n_acc + 1));
    check($sformatf("%s.bus_phases", tag), 64'(proto_ok), 64'(1));
    check($sformatf("%s.bus_idle_in_resp", tag), 64'({PSEL, PENABLE}), 64'(0));
    check($sformatf("%s.rsp_rdata", tag), 64'(rsp_rdata), 64'(e_rd));
    check($sformatf("%s.rsp_err", tag), 64'(rsp_err), 64'(e_err));
    check($sformatf("%s.rsp_timeout", tag), 64'(rsp_timeout), 64'(e_to));

    for (int h = 0; h < hold; h++) begin
      PREADY  = rbit();
      PRDATA  = $urandom;
      PSLVERR = rbit();
      @(posedge PCLK); #1;
      if (rsp_valid !== 1'b1 || rsp_rdata !== e_rd || rsp_err !== e_err ||
          rsp_timeout !== e_to || PSEL !== 1'b0 || PENABLE !== 1'b0 ||
          req_ready !== 1'b0) hold_ok = 1'b0;
    end
    PREADY = 1'b0;
    check($sformatf("%s.rsp_hold", tag), 64'(hold_ok), 64'(1));

    rsp_ready = 1'b1;
    @(posedge PCLK); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check($sformatf("%s.rsp_consumed", tag), 64'(rsp_valid), 64'(0));
    check($sformatf("%s.idle_ready", tag), 64'(req_ready), 64'(1));
  endtask

  initial begin
    PRESET    = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_write = 1'b0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    PRDATA    = '0;
    PREADY    = 1'b0;
    PSLVERR   = 1'b0;

    // Reset state
    repeat (3) @(posedge PCLK);
    #1;
    check("rst.psel", 64'(PSEL), 64'(0));
    check("rst.penable", 64'(PENABLE), 64'(0));
    check("rst.pwrite", 64'(PWRITE), 64'(0));
    check("rst.paddr", 64'(PADDR), 64'(0));
    check("rst.pwdata", 64'(PWDATA), 64'(0));
    check("rst.rsp_valid", 64'(rsp_valid), 64'(0));
    check("rst.rsp_fields", 64'({rsp_rdata, rsp_err, rsp_timeout}), 64'(0));
    check("rst.req_ready_in_reset", 64'(req_ready), 64'(0));
    PRESET = 1'b0;
    #1;
    check("rst.req_ready_after", 64'(req_ready), 64'(1));

    // Zero-wait write: PSEL at N+1, PENABLE at N+2, response at N+3
    xfer("wr_0c", 8'h0C, 1'b1, 32'hDEADBEEF, 0, 32'hFFFF_FFFF, 1'b0, 0, 1'b0);
    // Read with three wait states; PREADY lands on the TIMEOUT-th cycle
    xfer("rd_04_w3", 8'h04, 1'b0, 32'h1111_2222, 3, 32'h0000_0055, 1'b0, 0, 1'b0);
    // Slave error on completion
    xfer("rd_slverr", 8'h20, 1'b0, 32'h0, 1, 32'hCAFE_F00D, 1'b1, 1, 1'b0);
    // PREADY held low: abort after the 4th ACCESS cycle
    xfer("rd_timeout", 8'h30, 1'b0, 32'h0, 20, 32'h1234_5678, 1'b0, 0, 1'b0);
    // Exactly TIMEOUT wait states also aborts
    xfer("wr_timeout_edge", 8'h31, 1'b1, 32'hA5A5_5A5A, 4, 32'h0, 1'b0, 2, 1'b0);
    // Normal read after a timeout must clear rsp_timeout/rsp_err
    xfer("rd_after_to", 8'h44, 1'b0, 32'h0, 0, 32'h8765_4321, 1'b0, 0, 1'b0);
    // Response back-pressure with a new command already offered
    xfer("rd_backpressure", 8'h50, 1'b0, 32'h0, 2, 32'h0BAD_BEEF, 1'b0, 10, 1'b1);

    // Reset pulsed during ACCESS abandons the transfer
    req_addr  = 8'h66;
    req_write = 1'b1;
    req_wdata = 32'h1357_9BDF;
    req_valid = 1'b1;
    PREADY    = 1'b0;
    @(posedge PCLK); #1;
    req_valid = 1'b0;
    @(posedge PCLK); #1;
    check("rstmid.in_access", 64'({PSEL, PENABLE}), 64'(3));
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    check("rstmid.psel", 64'({PSEL, PENABLE}), 64'(0));
    check("rstmid.rsp_valid", 64'(rsp_valid), 64'(0));
    check("rstmid.req_ready", 64'(req_ready), 64'(0));
    check("rstmid.bus_fields", 64'({PADDR, PWRITE, PWDATA}), 64'(0));
    PRESET = 1'b0;
    #1;
    check("rstmid.idle", 64'(req_ready), 64'(1));
    @(posedge PCLK); #1;
    check("rstmid.no_rsp", 64'({rsp_valid, PSEL}), 64'(0));
    xfer("after_rst", 8'h67, 1'b0, 32'h0, 1, 32'h2468_ACE0, 1'b0, 0, 1'b0);

    // Randomized transfers, wait states spanning both sides of the timeout
    for (int i = 0; i < 24; i++) begin
      xfer($sformatf("rnd%0d", i), 8'($urandom), rbit(), $urandom,
           int'($urandom_range(0, 6)), $urandom, rbit(),
           int'($urandom_range(0, 3)), rbit());
      repeat ($urandom_range(0, 2)) @(posedge PCLK);
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
